delta_adc_ctrl: RTL and testbench

DELTA_ADC_CTRL -- requirements
Module: delta_adc_ctrl

---
 rtl/delta_adc_ctrl.sv | 158 +++++++++++++++
 tb/tb_delta_adc_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_adc_ctrl.sv
// Delta-tracking ADC controller.
// Drives an external DAC and moves the code one step up or down per
// comparator decision, publishing the code after nsamp+1 steps through
// a valid/ready result port with a sticky overrun flag.
module delta_adc_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic [7:0]       settle,
    input  logic [3:0]       nsamp,
    input  logic [1:0]       step,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, UPDATE} state_t;

    localparam logic [WIDTH-1:0] MID_CODE = {1'b1, {(WIDTH-1){1'b0}}};

    state_t       state;
    logic         cmp_s1;
    logic         cmp_s;
    logic [7:0]   settle_l;
    logic [3:0]   nsamp_l;
    logic [1:0]   step_l;
    logic         cont_l;
    logic [7:0]   set_cnt;
    logic [4:0]   step_cnt;
    logic         dir;

    logic [7:0]       settle_last;
    logic [4:0]       step_cnt_nxt;
    logic             last_step;
    logic             keep_going;
    logic [WIDTH-1:0] code_nxt;

    // One tracking step in WIDTH+1 bits; the extra bit flags carry/borrow
    // and the result clamps to the code range instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] code,
                                                  input logic [1:0]       exp,
                                                  input logic             up);
        logic [WIDTH:0] ext;
        logic [WIDTH:0] sz;
        ext = {1'b0, code};
        sz  = {{(WIDTH-3){1'b0}}, 4'b0001} << exp;
        if (up) begin
            ext = ext + sz;
            return ext[WIDTH] ? {WIDTH{1'b1}} : ext[WIDTH-1:0];
        end
        ext = ext - sz;
        return ext[WIDTH] ? {WIDTH{1'b0}} : ext[WIDTH-1:0];
    endfunction

    // A settle setting of 0 behaves like 1, so the last settle count is 0 either way.
    always_comb begin
        settle_last  = (settle_l == 8'd0) ? 8'd0 : settle_l - 8'd1;
        step_cnt_nxt = step_cnt + 5'd1;
        last_step    = (step_cnt_nxt == ({1'b0, nsamp_l} + 5'd1));
        keep_going   = cont_l & cont;
        code_nxt     = sat_step(dac_code, step_l, dir);
    end

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_s1 <= 1'b0;
            cmp_s  <= 1'b0;
        end else begin
            cmp_s1 <= cmp_in;
            cmp_s  <= cmp_s1;
        end
    end

    // Conversion FSM with tracking code, result register and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            dac_code  <= MID_CODE;
            res_data  <= '0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
            settle_l  <= '0;
            nsamp_l   <= '0;
            step_l    <= '0;
            cont_l    <= 1'b0;
            set_cnt   <= '0;
            step_cnt  <= '0;
            dir       <= 1'b0;
        end else begin
            // A transfer drops valid; a publish below on the same edge wins.
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        settle_l <= settle;
                        nsamp_l  <= nsamp;
                        step_l   <= step;
                        cont_l   <= cont;
                        step_cnt <= '0;
                        set_cnt  <= '0;
                        overrun  <= 1'b0;
                        state    <= SETTLE;
                        busy     <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (set_cnt == settle_last) begin
                        set_cnt <= '0;
                        state   <= SAMPLE;
                    end else begin
                        set_cnt <= set_cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    dir   <= cmp_s;
                    state <= UPDATE;
                end
                UPDATE: begin
                    dac_code <= code_nxt;
                    if (last_step) begin
                        res_data  <= code_nxt;
                        res_valid <= 1'b1;
                        if (res_valid && !res_ready) begin
                            overrun <= 1'b1;
                        end
                        step_cnt <= '0;
                        cont_l   <= keep_going;
                        if (keep_going) begin
                            state <= SETTLE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        step_cnt <= step_cnt_nxt;
                        state    <= SETTLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delta_adc_ctrl.sv
// Testbench for delta_adc_ctrl: directed sequence plus randomized conversions
// checked against an arithmetic model of the tracking code.
module tb_delta_adc_ctrl;

    localparam int W    = 8;
    localparam int MAXC = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic         cont;
    logic [7:0]   settle;
    logic [3:0]   nsamp;
    logic [1:0]   step;
    logic         cmp_in;
    logic [W-1:0] dac_code;
    logic         busy;
    logic [W-1:0] res_data;
    logic         res_valid;
    logic         res_ready;
    logic         overrun;

    int vectors     = 0;
    int miscompares = 0;
    int model_code  = 0;

    delta_adc_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .settle    (settle),
        .nsamp     (nsamp),
        .step      (step),
        .cmp_in    (cmp_in),
        .dac_code  (dac_code),
        .busy      (busy),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected code after n+1 steps of size 2^st in one direction, clamped to the code range.
    function automatic int conv_model(input int code, input int n, input int st, input bit up);
        int c;
        int sz;
        c  = code;
        sz = 1 << st;
        for (int i = 0; i <= n; i++) begin
            if (up) c = (c + sz > MAXC) ? MAXC : c + sz;
            else    c = (c - sz < 0) ? 0 : c - sz;
        end
        return c;
    endfunction

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 500) begin
            tick();
            k++;
        end
        chk({tag, "_idle_timeout"}, (k < 500) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // One single-shot conversion with a constant comparator level.
    task automatic run_conv(input int s, input int n, input int st, input bit up, input string tag);
        int cnt;
        int exp_lat;
        bit seen;
        cmp_in    = up;
        settle    = 8'(s);
        nsamp     = 4'(n);
        step      = 2'(st);
        cont      = 1'b0;
        res_ready = 1'b1;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        exp_lat = (n + 1) * (((s == 0) ? 1 : s) + 2);
        cnt  = 0;
        seen = 0;
        while (cnt < 2000 && !seen) begin
            tick();
            cnt++;
            if (res_valid === 1'b1) seen = 1;
        end
        chk({tag, "_latency"}, cnt, exp_lat);
        model_code = conv_model(model_code, n, st, up);
        chk({tag, "_res_data"}, res_data, model_code);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        bit up;
        rst       = 1'b1;
        start     = 1'b0;
        cont      = 1'b0;
        settle    = 8'd0;
        nsamp     = 4'd0;
        step      = 2'd0;
        cmp_in    = 1'b0;
        res_ready = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_dac", dac_code, 8'h80);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_overrun", overrun, 0);
        model_code = 128;

        // Single conversion, 16-edge latency, result 0x84
        run_conv(2, 3, 0, 1'b1, "single");
        chk("single_const", res_data, 8'h84);

        // Saturation high then low
        run_conv(1, 15, 3, 1'b1, "sat_up0");
        run_conv(1, 15, 3, 1'b1, "sat_up1");
        chk("sat_high", dac_code, 8'hFF);
        run_conv(1, 15, 3, 1'b0, "sat_dn0");
        run_conv(1, 15, 3, 1'b0, "sat_dn1");
        run_conv(1, 15, 3, 1'b0, "sat_dn2");
        chk("sat_low", dac_code, 8'h00);

        // Overrun in continuous mode with the consumer stalled
        cmp_in = 1'b1; settle = 8'd1; nsamp = 4'd0; step = 2'd0;
        res_ready = 1'b1;
        tick();
        tick();
        cont = 1'b1;
        res_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        model_code = conv_model(model_code, 0, 0, 1'b1);
        chk("ovr_first_valid", res_valid, 1);
        chk("ovr_first_flag", overrun, 0);
        chk("ovr_first_data", res_data, model_code);
        tick(); tick(); tick();
        model_code = conv_model(model_code, 0, 0, 1'b1);
        chk("ovr_second_flag", overrun, 1);
        chk("ovr_second_data", res_data, model_code);
        chk("ovr_second_valid", res_valid, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("ovr_accept_valid", res_valid, 0);
        cont = 1'b0;
        wait_idle("ovr_stop");
        model_code = conv_model(model_code, 0, 0, 1'b1);
        chk("ovr_stop_dac", dac_code, model_code);
        chk("ovr_sticky", overrun, 1);
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovr_cleared", overrun, 0);
        wait_idle("ovr_restart");
        model_code = conv_model(model_code, 0, 0, 1'b1);
        chk("ovr_restart_data", res_data, model_code);

        // Publish on the same edge as a transfer
        up = (model_code < 128);
        cmp_in = up; settle = 8'd1; nsamp = 4'd0; step = 2'd2;
        res_ready = 1'b1;
        tick();
        tick();
        cont = 1'b1;
        res_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        model_code = conv_model(model_code, 0, 2, up);
        chk("sim_first_data", res_data, model_code);
        tick(); tick();
        res_ready = 1'b1;
        tick();
        model_code = conv_model(model_code, 0, 2, up);
        chk("sim_coinc_valid", res_valid, 1);
        chk("sim_coinc_data", res_data, model_code);
        chk("sim_coinc_overrun", overrun, 0);
        for (int k = 0; k < 3; k++) begin
            tick(); tick(); tick();
            model_code = conv_model(model_code, 0, 2, up);
            chk("sim_stream_valid", res_valid, 1);
            chk("sim_stream_data", res_data, model_code);
        end
        cont = 1'b0;
        wait_idle("sim_stop");
        model_code = conv_model(model_code, 0, 2, up);
        chk("sim_stop_data", res_data, model_code);
        chk("sim_overrun", overrun, 0);

        // Reset while in SAMPLE
        cmp_in = 1'b1; settle = 8'd3; nsamp = 4'd2; step = 2'd1;
        res_ready = 1'b1;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_busy", busy, 0);
        chk("rmid_dac", dac_code, 8'h80);
        chk("rmid_valid", res_valid, 0);
        model_code = 128;
        run_conv(2, 1, 1, 1'b1, "rmid_after");

        // Randomized single conversions
        for (int i = 0; i < 12; i++) begin
            run_conv(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand");
            chk("rand_dac", dac_code, model_code);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
